// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run control and PC in, program-load port in,
// registered instruction word, its address and run status out.
interface instr_fetch_if #(
    parameter int A  = 10,
    parameter int W  = 9,
    parameter int CW = 16
);
    logic          Start;
    logic [A-1:0]  ProgCtr;
    logic          Flush;
    logic          InstrWe;
    logic [A-1:0]  InstrWaddr;
    logic [W-1:0]  InstrWdata;
    logic [W-1:0]  Instruction;
    logic          InstrValid;
    logic [A-1:0]  FetchPc;
    logic          Done;
    logic [CW-1:0] CycleCount;

    modport master (
        output Start, ProgCtr, Flush, InstrWe, InstrWaddr, InstrWdata,
        input  Instruction, InstrValid, FetchPc, Done, CycleCount
    );

    modport slave (
        input  Start, ProgCtr, Flush, InstrWe, InstrWaddr, InstrWdata,
        output Instruction, InstrValid, FetchPc, Done, CycleCount
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: synchronous instruction memory read at the PC,
// one-cycle flush bubbles, Start/Done run control stopping on a halt word,
// and a saturating count of fetch cycles spent running.
module instr_fetch #(
    parameter int           A    = 10,
    parameter int           W    = 9,
    parameter logic [W-1:0] HALT = 9'h1FF,
    parameter int           CW   = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        Idle,
        Armed,
        Run,
        Halted
    } state_t;

    state_t        state;
    state_t        nextState;

    logic [W-1:0]  mem [2**A];

    logic [W-1:0]  instrReg;
    logic          validReg;
    logic [A-1:0]  pcReg;
    logic          doneReg;
    logic [CW-1:0] countReg;

    logic          haltSeen;
    logic          runStay;
    logic          enterArmed;
    logic          loadOk;

    // A halt only retires when it is live and not sitting in a flushed shadow.
    assign haltSeen   = validReg && (instrReg == HALT) && !bus.Flush;
    assign runStay    = (state == Run) && (nextState == Run);
    assign enterArmed = (nextState == Armed) && (state != Armed);
    assign loadOk     = (state == Idle) || (state == Halted);

    // Next-state logic for the run-control FSM; Start in RUN aborts ahead of a halt.
    always_comb begin
        nextState = state;
        case (state)
            Idle:    if (bus.Start) nextState = Armed;
            Armed:   if (!bus.Start) nextState = Run;
            Run: begin
                if (bus.Start)     nextState = Armed;
                else if (haltSeen) nextState = Halted;
            end
            Halted:  if (bus.Start) nextState = Armed;
            default: nextState = Idle;
        endcase
    end

    // Run-control state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= Idle;
        else        state <= nextState;
    end

    // Program-load port; the core must be stopped for writes to land, and reset leaves contents alone.
    always_ff @(posedge Clk) begin
        if (bus.InstrWe && loadOk) mem[bus.InstrWaddr] <= bus.InstrWdata;
    end

    // Registered fetch: read the word at the PC while running, otherwise present an empty slot.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instrReg <= '0;
            validReg <= 1'b0;
            pcReg    <= '0;
        end else begin
            if (state == Run) pcReg <= bus.ProgCtr;
            if (runStay && !bus.Flush) begin
                instrReg <= mem[bus.ProgCtr];
                validReg <= 1'b1;
            end else begin
                instrReg <= '0;
                validReg <= 1'b0;
            end
        end
    end

    // Done flag and saturating fetch-cycle counter; the halt-retire edge is not counted.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            doneReg  <= 1'b0;
            countReg <= '0;
        end else if (enterArmed) begin
            doneReg  <= 1'b0;
            countReg <= '0;
        end else begin
            if ((state == Run) && (nextState == Halted)) doneReg <= 1'b1;
            if (runStay && (countReg != '1)) countReg <= countReg + CW'(1);
        end
    end

    assign bus.Instruction = instrReg;
    assign bus.InstrValid  = validReg;
    assign bus.FetchPc     = pcReg;
    assign bus.Done        = doneReg;
    assign bus.CycleCount  = countReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a vector table drives Start/PC/Flush per cycle,
// expected fetch results go onto a scoreboard queue when the fetch is issued
// and are popped when the DUT presents a valid instruction.
module tb_instr_fetch;

    localparam int A  = 10;
    localparam int W  = 9;
    localparam int CW = 4;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    instr_fetch_if #(.A(A), .W(W), .CW(CW)) bus ();

    instr_fetch #(.A(A), .W(W), .HALT(9'h1FF), .CW(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic         start;
        logic [A-1:0] pc;
        logic         flush;
        logic         we;
        logic         push;
        logic         expDone;
        int           expCount;
    } vec_t;

    typedef struct {
        logic [W-1:0] instr;
        logic [A-1:0] pc;
    } exp_t;

    exp_t         sbQ [$];
    vec_t         vecs [$];
    logic [W-1:0] progMem [0:31];
    int           total = 0;
    int           bad   = 0;

    function automatic vec_t mk(logic start, int pc, logic flush, logic we,
                                logic push, logic expDone, int expCount);
        vec_t v;
        v.start    = start;
        v.pc       = A'(pc);
        v.flush    = flush;
        v.we       = we;
        v.push     = push;
        v.expDone  = expDone;
        v.expCount = expCount;
        return v;
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        exp_t e;
        bus.Start      = v.start;
        bus.ProgCtr    = v.pc;
        bus.Flush      = v.flush;
        bus.InstrWe    = v.we;
        bus.InstrWaddr = A'(1);
        bus.InstrWdata = 9'h055;
        if (v.push) begin
            e.instr = progMem[v.pc[4:0]];
            e.pc    = v.pc;
            sbQ.push_back(e);
        end
        @(posedge Clk);
        #1;
        bus.InstrWe = 1'b0;
    endtask

    task automatic checkOutput(string name, vec_t v);
        exp_t e;
        checkVal({name, ".valid"}, 32'(bus.InstrValid), 32'(v.push));
        if (bus.InstrValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL %s.sb: got word 0x%0h, expected no output", name, bus.Instruction);
            end else begin
                e = sbQ.pop_front();
                checkVal({name, ".instr"}, 32'(bus.Instruction), 32'(e.instr));
                checkVal({name, ".pc"}, 32'(bus.FetchPc), 32'(e.pc));
            end
        end else begin
            checkVal({name, ".instr0"}, 32'(bus.Instruction), 32'd0);
            if (v.push && sbQ.size() != 0) void'(sbQ.pop_front());
        end
        checkVal({name, ".done"}, 32'(bus.Done), 32'(v.expDone));
        checkVal({name, ".count"}, 32'(bus.CycleCount), 32'(v.expCount));
    endtask

    task automatic runVec(string name, vec_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    task automatic loadWord(int addr, logic [W-1:0] data);
        bus.Start      = 1'b0;
        bus.Flush      = 1'b0;
        bus.InstrWe    = 1'b1;
        bus.InstrWaddr = A'(addr);
        bus.InstrWdata = data;
        progMem[addr]  = data;
        @(posedge Clk);
        #1;
        bus.InstrWe = 1'b0;
    endtask

    task automatic checkAllZero(string name);
        checkVal({name, ".instr"}, 32'(bus.Instruction), 32'd0);
        checkVal({name, ".valid"}, 32'(bus.InstrValid), 32'd0);
        checkVal({name, ".pc"}, 32'(bus.FetchPc), 32'd0);
        checkVal({name, ".done"}, 32'(bus.Done), 32'd0);
        checkVal({name, ".count"}, 32'(bus.CycleCount), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) progMem[i] = '0;
        bus.Start      = 1'b0;
        bus.ProgCtr    = '0;
        bus.Flush      = 1'b0;
        bus.InstrWe    = 1'b0;
        bus.InstrWaddr = '0;
        bus.InstrWdata = '0;
        Reset          = 1'b0;

        #12;
        checkAllZero("reset");
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        loadWord(0, 9'h001);
        loadWord(1, 9'h002);
        loadWord(2, 9'h003);
        loadWord(3, 9'h1FF);
        loadWord(8, 9'h0A8);
        loadWord(9, 9'h0A9);
        loadWord(10, 9'h1FF);

        // start, pc, flush, we, push, expDone, expCount
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0,  2, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0,  3, 0, 0, 1, 0, 4));
        vecs.push_back(mk(0,  4, 0, 0, 0, 1, 4));
        vecs.push_back(mk(0,  5, 0, 0, 0, 1, 4));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0,  2, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0,  8, 0, 0, 1, 0, 4));
        vecs.push_back(mk(0,  3, 0, 0, 1, 0, 5));
        vecs.push_back(mk(0,  4, 1, 0, 0, 0, 6));
        vecs.push_back(mk(0,  9, 0, 1, 1, 0, 7));
        vecs.push_back(mk(0,  1, 0, 0, 1, 0, 8));
        vecs.push_back(mk(0, 10, 0, 0, 1, 0, 9));
        vecs.push_back(mk(0, 11, 0, 0, 0, 1, 9));

        foreach (vecs[i]) runVec($sformatf("v%0d", i), vecs[i]);

        // Asynchronous reset between edges in the middle of a run.
        runVec("mr0", mk(1, 0, 0, 0, 0, 0, 0));
        runVec("mr1", mk(0, 0, 0, 0, 0, 0, 0));
        runVec("mr2", mk(0, 0, 0, 0, 1, 0, 1));
        runVec("mr3", mk(0, 1, 0, 0, 1, 0, 2));
        #2;
        Reset = 1'b0;
        #1;
        checkAllZero("midReset");
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) runVec($sformatf("idle%0d", i), mk(0, i, 0, 0, 0, 0, 0));

        // Long program to push the counter into saturation.
        for (int i = 0; i < 20; i++) loadWord(i, 9'(9'h100 + i));
        loadWord(20, 9'h1FF);
        runVec("sat.arm", mk(1, 0, 0, 0, 0, 0, 0));
        runVec("sat.go", mk(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= 20; i++)
            runVec($sformatf("sat%0d", i), mk(0, i, 0, 0, 1, 0, (i + 1 > 15) ? 15 : i + 1));
        runVec("sat.halt", mk(0, 21, 0, 0, 0, 1, 15));
        runVec("sat.hold", mk(0, 22, 0, 0, 0, 1, 15));

        checkVal("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of `ProgCtr`. Takes the 10-bit `ProgCtr` address and reads a synchronous instruction memory into a registered instruction word for the decoder. It also provides:

- the address of that word;
- one-cycle flush bubbles after taken branches;
- a Start/Done run-control FSM that stops the run on a halt instruction;
- a fetch-cycle counter.

The program is loaded through a write port while the core is idle.

## Interface

Parameters:

- `A`, 10, instruction address width (matches `ProgCtr`)
- `W`, 9, instruction width
- `HALT`, 9'h1FF, halt opcode
- `CW`, 16, cycle-counter width

Ports:

- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  run request from harness (same pulse that drives `ProgCtr.Start`)
- `ProgCtr`  in  A  fetch address from program counter
- `Flush`  in  1  from decoder: branch taken this cycle; squash the in-flight fetch
- `InstrWe`  in  1  program-load write enable
- `InstrWaddr`  in  A  program-load address
- `InstrWdata`  in  W  program-load data
- `Instruction`  out  W  registered instruction word; 0 when not valid
- `InstrValid`  out  1  `Instruction` is a live instruction for decode
- `FetchPc`  out  A  address `Instruction` was read from
- `Done`  out  1  program halted
- `CycleCount`  out  CW  fetch cycles spent in RUN

## Operation

- **Memory**
  - 2**A × W, synchronous read.
  - Writes are accepted only in IDLE or DONE. `InstrWe` in ARMED or RUN is ignored.
  - Contents are not affected by reset.
- **States:** IDLE, ARMED, RUN, DONE.
  - IDLE --Start=1--> ARMED
  - ARMED --Start=0--> RUN
  - RUN --halt retired--> DONE
  - DONE --Start=1--> ARMED
  - RUN --Start=1--> ARMED (abort; current instruction discarded)
  - ARMED holds while Start=1.
- **RUN, each cycle:**
  - `Instruction` <= mem[`ProgCtr`], `FetchPc` <= `ProgCtr`.
  - `InstrValid` <= 1, unless `Flush`=1 that cycle. In that case `InstrValid` <= 0 and `Instruction` <= 0 (one bubble).
- **Halt:** in RUN, when `InstrValid`=1 and `Instruction`==`HALT`:
  - next edge goes to DONE, `Done` <= 1, `InstrValid` <= 0, `Instruction` <= 0.
  - Halt is ignored if `Flush`=1 in the same cycle, because the flush takes priority (the halt is in a squashed shadow).
- **Outside RUN:** `InstrValid`=0 and `Instruction`=0. `FetchPc` holds its last value.
- **`Done`:** stays 1 throughout DONE; cleared on entry to ARMED.
- **`CycleCount`:**
  - cleared on entry to ARMED;
  - +1 on every RUN cycle, bubbles included;
  - saturates at 2**CW-1, with no wrap;
  - holds in DONE.
- **Async reset (Reset=0), any time including mid-run:**
  - state IDLE, `Instruction`=0, `InstrValid`=0, `FetchPc`=0, `Done`=0, `CycleCount`=0;
  - takes effect immediately, without waiting for a clock edge.

## Timing

- Fetch latency is 1 cycle: the address on `ProgCtr` during cycle n appears on `Instruction`/`FetchPc` in cycle n+1.
- First valid instruction: `ProgCtr`=0 during the first RUN cycle (the cycle after Start falls). `Instruction`=mem[0] and `InstrValid`=1 in the following cycle.
- Branch penalty:
  - The decoder asserts `Flush` in the same cycle it asserts `BranchAbsEn`, or `BranchRelEn` with the flag true.
  - The next cycle is a bubble.
  - The target instruction is valid the cycle after that.
- Halt to `Done`: 1 edge after the halt word is valid on `Instruction`.
- Start in RUN: `InstrValid` drops at the next edge.
- `CycleCount` is registered and reflects completed RUN edges.

## Test plan

- **Reset and load:**
  - Stimulus: Reset=0, then 1; write mem[0..3]={9'h001,9'h002,9'h003,9'h1FF} in IDLE; pulse Start for 1 cycle.
  - Required response: `Instruction`=001,002,003 with `FetchPc`=0,1,2 and `InstrValid`=1; then `Done`=1 and `InstrValid`=0 one edge after 1FF is shown; `CycleCount`=4.
- **Flush:**
  - Stimulus: same program; `Flush`=1 while `Instruction`=002.
  - Required response: the next cycle has `InstrValid`=0 and `Instruction`=0, and the word after that is `Instruction`=mem[`ProgCtr`] of the redirected PC.
- **Squashed halt:**
  - Stimulus: 1FF arrives in the same cycle as `Flush`=1.
  - Required response: `Done` stays 0 and RUN continues.
- **Write lockout and restart:**
  - Stimulus: `InstrWe`=1 to address 1 with 9'h055 during RUN, later read back.
  - Required response: the readback is unchanged (002).
  - Stimulus: after DONE, Start high for 2 cycles.
  - Required response: state is ARMED, `Done`=0, `CycleCount`=0, and the program reruns from `FetchPc`=0.
- **Mid-run reset:**
  - Stimulus: Reset=0 asynchronously between edges during RUN.
  - Required response: all outputs are 0 before the next edge.
  - Stimulus: release Reset without a Start.
  - Required response: the block stays in IDLE with `InstrValid`=0.
- **Saturation (CW=4):**
  - Stimulus: run a 20-instruction program.
  - Required response: `CycleCount` sticks at 15.
